fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Issues requests to instruction memory and hands
// fetched words to the IF/ID pipeline register. A downstream stall parks a
// returned word in a one-entry holding buffer. A redirect, from a branch or an
// exception, drops the word fetched or buffered in that cycle. If a redirect
// arrives while a request is still outstanding, the late response is discarded
// and fetch resumes at the pending target.
//
// Optional build macro:
//   FETCH_BUBBLE_NOP_EN : on every redirect cycle, load IF/ID with an A64 NOP
//                         (if_id_en=1, fetch_valid=0), which flushes it to a
//                         bubble. When undefined, IF/ID keeps its previous
//                         contents on redirect cycles.
//
// Parameters:
//   RESET_PC    : PC value loaded while reset is high.
//
// Ports:
//   clk         : single clock; all state updates on the rising edge
//   reset       : asynchronous, active-high reset
//   stall       : hold request from downstream
//   redirect    : branch/exception redirect request
//   redirect_PC : redirect target (bits [1:0] are forced to zero)
//   imem_req    : instruction-memory request
//   imem_addr   : request address
//   imem_ready  : memory response valid this cycle
//   imem_data   : returned instruction word
//   PC_out      : PC of the delivered instruction (to IF/ID)
//   instr_out   : delivered instruction (to IF/ID)
//   if_id_en    : IF/ID load enable
//   fetch_valid : instr_out is a real fetched instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_PC,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [63:0] PC_out,
  output logic [31:0] instr_out,
  output logic        if_id_en,
  output logic        fetch_valid
);

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [63:0] pending, pending_nxt;
  logic [31:0] buffer, buffer_nxt;
  logic        bubble;

  // Instruction fetch is word aligned, so redirect targets drop their low bits.
  function automatic logic [63:0] align_target(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

  // Sequential PC advance; wraps modulo 2^64.
  function automatic logic [63:0] pc_inc(input logic [63:0] addr);
    return addr + 64'd4;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      buffer  <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      buffer  <= buffer_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pending_nxt = pending;
    buffer_nxt  = buffer;
    imem_req    = 1'b0;
    // The request address is always the current PC. In DISCARD the PC has
    // not yet moved, so the outstanding address stays stable.
    imem_addr   = pc;
    PC_out      = pc;
    instr_out   = buffer;
    if_id_en    = 1'b0;
    fetch_valid = 1'b0;
    bubble      = 1'b0;

    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redirect) begin
          bubble = 1'b1;
          pc_nxt = align_target(redirect_PC);
        end
      end

      REQ: begin
        imem_req  = 1'b1;
        instr_out = imem_data;
        if (redirect) begin
          bubble = 1'b1;
          if (imem_ready) begin
            pc_nxt = align_target(redirect_PC);
          end else begin
            // The response is still in flight. Its data must be swallowed
            // before the PC can move.
            pending_nxt = align_target(redirect_PC);
            state_nxt   = DISCARD;
          end
        end else if (imem_ready) begin
          if (stall) begin
            buffer_nxt = imem_data;
            state_nxt  = HOLD;
          end else begin
            if_id_en    = 1'b1;
            fetch_valid = 1'b1;
            pc_nxt      = pc_inc(pc);
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          bubble    = 1'b1;
          pc_nxt    = align_target(redirect_PC);
          state_nxt = REQ;
        end else if (!stall) begin
          if_id_en    = 1'b1;
          fetch_valid = 1'b1;
          pc_nxt      = pc_inc(pc);
          state_nxt   = REQ;
        end
      end

      DISCARD: begin
        imem_req = 1'b1;
        if (redirect) begin
          bubble = 1'b1;
          // The newest redirect wins. If the stale response lands in this
          // same cycle, jump straight to the new target.
          if (imem_ready) begin
            pc_nxt    = align_target(redirect_PC);
            state_nxt = REQ;
          end else begin
            pending_nxt = align_target(redirect_PC);
          end
        end else if (imem_ready) begin
          pc_nxt    = pending;
          state_nxt = REQ;
        end
      end

      default: state_nxt = IDLE;
    endcase

`ifdef FETCH_BUBBLE_NOP_EN
    // Flush IF/ID to a NOP bubble on redirect. This is suppressed while reset
    // is asserted so that outputs keep their reset values.
    if (bubble && !reset) begin
      if_id_en    = 1'b1;
      fetch_valid = 1'b0;
      instr_out   = NOP_INSTR;
    end
`else
    // Without the bubble option, IF/ID keeps its contents on redirect cycles.
    if (bubble) begin
      if_id_en    = 1'b0;
      fetch_valid = 1'b0;
    end
`endif
  end

endmodule
